// File: rtl/xmpl_dsp_acc_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// xmpl_dsp_acc_fsm : multi-channel saturating accumulate sequencer
// Revision 1.0
// ============================================================================
module xmpl_dsp_acc_fsm #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 32,
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [$clog2(NUM_CH)-1:0] ch_i,
    input  logic [LEN_W-1:0]          len_i,
    input  logic                      keep_i,
    input  logic                      samp_valid_i,
    output logic                      samp_ready_o,
    input  logic [DATA_W-1:0]         samp_data_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [ACC_W-1:0]          res_data_o,
    output logic [$clog2(NUM_CH)-1:0] res_ch_o,
    output logic                      busy_o,
    output logic [31:0]               status_o
);

    localparam int               CH_W    = $clog2(NUM_CH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic               sat_q;
    logic               err_len_q;
    logic [7:0]         ops_q;
    logic               samp_ready_q;
    logic               res_valid_q;
    logic               busy_q;
    logic [ACC_W-1:0]   bank_q [NUM_CH];

    logic [ACC_W:0]     sum_d;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;
    logic               last_d;

    // One guard bit above the accumulator: overflow shows as guard != MSB.
    always_comb begin
        sum_d  = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W+1-DATA_W){samp_data_i[DATA_W-1]}}, samp_data_i};
        ovf_d  = sum_d[ACC_W] ^ sum_d[ACC_W-1];
        acc_d  = sum_d[ACC_W-1:0];
        if (ovf_d) begin
            acc_d = sum_d[ACC_W] ? ACC_NEG : ACC_POS;
        end
        last_d = (cnt_q == (len_q - LEN_ONE));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            err_len_q    <= 1'b0;
            ops_q        <= '0;
            samp_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            err_len_q <= 1'b1;
                        end else begin
                            ch_q         <= ch_i;
                            len_q        <= len_i;
                            acc_q        <= keep_i ? bank_q[ch_i] : '0;
                            cnt_q        <= '0;
                            sat_q        <= 1'b0;
                            err_len_q    <= 1'b0;
                            state_q      <= ST_ACCUM;
                            samp_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (samp_valid_i && samp_ready_q) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + LEN_ONE;
                        if (ovf_d) begin
                            sat_q <= 1'b1;
                        end
                        // Bank is written with the final value on the last-sample edge.
                        if (last_d) begin
                            bank_q[ch_q] <= acc_d;
                            state_q      <= ST_DONE;
                            samp_ready_q <= 1'b0;
                            res_valid_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ops_q       <= ops_q + 8'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    samp_ready_q <= 1'b0;
                    res_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign samp_ready_o = samp_ready_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = acc_q;
    assign res_ch_o     = ch_q;
    assign busy_o       = busy_q;
    assign status_o     = {16'h0000, ops_q, 4'(ch_q), err_len_q, sat_q, state_q};

endmodule
`default_nettype wire

// File: tb/tb_xmpl_dsp_acc_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_xmpl_dsp_acc_fsm : directed and randomized checks against a sum/clamp model
// Revision 1.0
// ============================================================================
module tb_xmpl_dsp_acc_fsm;

    localparam int DATA_W = 12;
    localparam int ACC_W  = 16;
    localparam int NUM_CH = 4;
    localparam int LEN_W  = 8;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              start_i;
    logic [1:0]        ch_i;
    logic [LEN_W-1:0]  len_i;
    logic              keep_i;
    logic              samp_valid_i;
    logic              samp_ready_o;
    logic [DATA_W-1:0] samp_data_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [ACC_W-1:0]  res_data_o;
    logic [1:0]        res_ch_o;
    logic              busy_o;
    logic [31:0]       status_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-channel results, sticky flags, op count
    longint m_bank [NUM_CH];
    longint m_acc;
    int     m_ops;
    int     m_ch;
    bit     m_sat;
    bit     m_err;
    int     q_samp [$];

    xmpl_dsp_acc_fsm #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .NUM_CH (NUM_CH),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .start_i      (start_i),
        .ch_i         (ch_i),
        .len_i        (len_i),
        .keep_i       (keep_i),
        .samp_valid_i (samp_valid_i),
        .samp_ready_o (samp_ready_o),
        .samp_data_i  (samp_data_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_ch_o     (res_ch_o),
        .busy_o       (busy_o),
        .status_o     (status_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int st);
        return {16'h0000, 8'(m_ops), 4'(m_ch), m_err, m_sat, 2'(st)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_bank[i] = 0;
        m_acc = 0; m_ops = 0; m_ch = 0; m_sat = 1'b0; m_err = 1'b0;
    endtask

    task automatic issue(input int ch, input int len, input bit keep);
        start_i = 1'b1;
        ch_i    = 2'(ch);
        len_i   = 8'(len);
        keep_i  = keep;
        step();
        start_i = 1'b0;
        ch_i    = 2'($urandom);
        len_i   = 8'($urandom);
        keep_i  = 1'($urandom);
        if (len == 0) begin
            m_err = 1'b1;
            chk("len0_busy", busy_o, 0);
            chk("len0_rdy", samp_ready_o, 0);
            chk("len0_status", status_o, exp_status(0));
        end else begin
            m_ch  = ch;
            m_acc = keep ? m_bank[ch] : 0;
            m_sat = 1'b0;
            m_err = 1'b0;
            chk("start_busy", busy_o, 1);
            chk("start_rdy", samp_ready_o, 1);
            chk("start_status", status_o, exp_status(1));
        end
    endtask

    task automatic feed(input bit rnd);
        for (int i = 0; i < q_samp.size(); i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    samp_valid_i = 1'b0;
                    samp_data_i  = 12'($urandom);
                    step();
                    chk("gap_rdy", samp_ready_o, 1);
                end
            end
            samp_valid_i = 1'b1;
            samp_data_i  = 12'(q_samp[i]);
            step();
            samp_valid_i = 1'b0;
            m_acc = m_acc + q_samp[i];
            if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
            if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
            if (i < q_samp.size() - 1) begin
                chk("mid_rdy", samp_ready_o, 1);
                chk("mid_vld", res_valid_o, 0);
            end else begin
                m_bank[m_ch] = m_acc;
                chk("res_vld", res_valid_o, 1);
                chk("res_rdy_low", samp_ready_o, 0);
                chk("res_data", $signed(res_data_o), m_acc);
                chk("res_ch", res_ch_o, m_ch);
                chk("done_status", status_o, exp_status(2));
            end
        end
    endtask

    task automatic finish_cmd(input int hold);
        for (int k = 0; k < hold; k++) begin
            start_i      = 1'($urandom);
            samp_valid_i = 1'($urandom);
            samp_data_i  = 12'($urandom);
            res_ready_i  = 1'b0;
            step();
            chk("hold_vld", res_valid_o, 1);
            chk("hold_data", $signed(res_data_o), m_acc);
            chk("hold_ch", res_ch_o, m_ch);
            chk("hold_rdy", samp_ready_o, 0);
            chk("hold_status", status_o, exp_status(2));
        end
        start_i      = 1'($urandom);
        samp_valid_i = 1'($urandom);
        res_ready_i  = 1'b1;
        step();
        start_i      = 1'b0;
        samp_valid_i = 1'b0;
        res_ready_i  = 1'b0;
        m_ops = (m_ops + 1) % 256;
        chk("hs_vld", res_valid_o, 0);
        chk("hs_busy", busy_o, 0);
        chk("hs_status", status_o, exp_status(0));
    endtask

    task automatic run(input int ch, input int len, input bit keep,
                       input bit rnd, input int hold);
        issue(ch, len, keep);
        feed(rnd);
        finish_cmd(hold);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        start_i      = 1'b0;
        ch_i         = '0;
        len_i        = '0;
        keep_i       = 1'b0;
        samp_valid_i = 1'b0;
        samp_data_i  = '0;
        res_ready_i  = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_rdy", samp_ready_o, 0);
        chk("rst_vld", res_valid_o, 0);
        chk("rst_data", res_data_o, 0);
        chk("rst_ch", res_ch_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_status", status_o, 0);
        reset_n_i = 1'b1;
        step();

        q_samp = '{5, -2, 7};
        run(1, 3, 1'b0, 1'b0, 0);
        chk("first_result", m_acc, 10);
        q_samp = '{1, 1};
        run(1, 2, 1'b1, 1'b0, 0);
        q_samp = '{3};
        run(2, 1, 1'b1, 1'b0, 0);

        // Positive and negative clamping, then sticky-clear by next start
        q_samp.delete();
        repeat (20) q_samp.push_back(2047);
        run(0, 20, 1'b0, 1'b0, 1);
        chk("sat_bit", status_o[2], 1);
        q_samp.delete();
        repeat (20) q_samp.push_back(-2048);
        run(3, 20, 1'b0, 1'b1, 0);
        q_samp = '{-5};
        run(3, 1, 1'b0, 1'b0, 0);

        // Zero length is rejected, next valid start clears the flag
        issue(1, 0, 1'b1);
        step();
        chk("len0_idle", status_o[1:0], 0);
        q_samp = '{-100, 50};
        run(1, 2, 1'b1, 1'b0, 0);

        // Long stall in DONE with start/sample pulses
        q_samp = '{1000, 999};
        run(0, 2, 1'b1, 1'b0, 10);

        // Abort mid-command by reset
        issue(2, 4, 1'b0);
        samp_valid_i = 1'b1;
        samp_data_i  = 12'(100);
        step();
        samp_data_i  = 12'(200);
        step();
        samp_valid_i = 1'b0;
        reset_n_i    = 1'b0;
        step();
        reset_n_i    = 1'b1;
        model_reset();
        chk("abort_vld", res_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_status", status_o, 0);
        step();
        chk("abort_novld", res_valid_o, 0);
        q_samp = '{4};
        run(2, 1, 1'b1, 1'b0, 0);
        chk("abort_result", m_acc, 4);

        // Maximum length
        q_samp.delete();
        repeat (255) q_samp.push_back(int'($urandom_range(0, 4095)) - 2048);
        run(3, 255, 1'b1, 1'b0, 0);

        // Randomized commands
        for (int n = 0; n < 30; n++) begin
            int len;
            int mode;
            len  = $urandom_range(1, 20);
            mode = $urandom_range(0, 5);
            q_samp.delete();
            for (int s = 0; s < len; s++) begin
                if (mode == 0)      q_samp.push_back(2047);
                else if (mode == 1) q_samp.push_back(-2048);
                else                q_samp.push_back(int'($urandom_range(0, 4095)) - 2048);
            end
            if ($urandom_range(0, 7) == 0) issue($urandom_range(0, 3), 0, 1'($urandom));
            run($urandom_range(0, 3), len, 1'($urandom), 1'b1, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xmpl_dsp_acc_fsm.md
Name: xmpl_dsp_acc_fsm

Overview:
Parametrised multi-channel accumulate sequencer. It is the next generation of the single-channel DSP control FSM. On a start command it accepts len_i signed samples through a valid/ready stream and accumulates them with saturation. It then presents one result per command through a valid/ready output. A per-channel result bank supports continue-from-previous accumulation, and a 32-bit status word exposes state and sticky flags to the register block.

Parameters:
DATA_W, 12, sample width, signed two's complement.
ACC_W, 32, accumulator and result width, signed; must be > DATA_W and <= 32.
NUM_CH, 4, number of channels; must be >= 2.
LEN_W, 8, width of the sample-count field.

Ports:
clk_i  in  1  clock, rising edge.
reset_n_i  in  1  reset; synchronous, active-low.
start_i  in  1  command strobe, sampled only in IDLE.
ch_i  in  $clog2(NUM_CH)  channel index for the command.
len_i  in  LEN_W  number of samples to accumulate.
keep_i  in  1  1 = seed accumulator from the channel bank; 0 = seed with 0.
samp_valid_i  in  1  sample valid.
samp_ready_o  out  1  sample ready.
samp_data_i  in  DATA_W  signed sample.
res_valid_o  out  1  result valid.
res_ready_i  in  1  result ready.
res_data_o  out  ACC_W  signed result.
res_ch_o  out  $clog2(NUM_CH)  channel of the result.
busy_o  out  1  high in any state other than IDLE.
status_o  out  32  status word.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - state=IDLE; all outputs 0; accumulator, sample counter and op counter cleared; every channel bank entry cleared to 0; sticky flags cleared.
  - Reset asserted mid-operation aborts the operation. No result is emitted and the bank is not updated.
- States: IDLE=0, ACCUM=1, DONE=2 (reported in status_o[1:0]).
- IDLE, start_i=1, len_i=0: stay IDLE; set sticky err_len (status_o[3]); nothing else changes.
- IDLE, start_i=1, len_i!=0:
  - latch ch_i, len_i and keep_i;
  - load acc = keep_i ? bank[ch_i] : 0;
  - clear counter, sat and err_len;
  - next state ACCUM.
- ACCUM:
  - samp_ready_o=1; every other state drives it 0.
  - On samp_valid_i&samp_ready_o: acc = sat(acc + sign_ext(samp_data_i)); counter++.
  - sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sticky sat (status_o[2]), which stays set until the next accepted start.
  - When the accepted sample makes counter==len: next state DONE and bank[ch] <= final acc on that same edge.
  - Latency: last sample accepted at edge t gives res_valid_o=1 in the cycle after t.
- DONE:
  - res_valid_o=1; res_data_o=acc; res_ch_o=latched channel. All three hold stable until res_valid_o&res_ready_i.
  - On the handshake edge: state goes to IDLE and op counter (status_o[15:8]) increments mod 256.
  - start_i in DONE, or in the handshake cycle, is ignored. A start is accepted at the earliest one cycle after the handshake.
- start_i asserted in ACCUM or DONE is ignored with no side effects.
- Signed addition is performed at ACC_W+1 bits before clamping, so no wrap-around can occur. The sample counter is LEN_W bits and never exceeds len.
- status_o layout:
  - [1:0] state;
  - [2] sat;
  - [3] err_len;
  - [7:4] latched channel (zero-extended);
  - [15:8] op count;
  - [31:16] 0.
- All outputs are driven from registers.

Test Plan:
- Reset, then start ch=1, len=3, keep=0 with samples 5, -2, 7 presented back-to-back -> samp_ready_o high for exactly 3 accepted samples; res_valid_o=1 one cycle after the third sample, res_data_o=10, res_ch_o=1, status_o[15:8]=1 after the handshake.
- Repeat the command with ch=1, len=2, keep=1, samples 1, 1 -> res_data_o=12. Then ch=2, keep=1, len=1, sample 3 -> res_data_o=3, confirming the banks are independent.
- ACC_W=16, len=20, all samples 2047 -> res_data_o=32767 and status_o[2]=1. Next accepted start clears status_o[2].
- start with len=0 -> stays IDLE, busy_o=0, status_o[3]=1. A following valid start clears status_o[3].
- Hold res_ready_i=0 for 10 cycles in DONE while pulsing start_i and samp_valid_i -> res_data_o stable, samp_ready_o=0, no new command accepted.
- Assert reset_n_i=0 after 2 of 4 samples, then run ch=same, keep=1, len=1, sample 4 -> res_data_o=4 (bank cleared, no result emitted from the aborted command).
